// File: rtl/reg_bank_bus_arbiter_pkg.sv
// Shared types and helpers for the register-bank bus arbiter.
package reg_bank_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        ACK   = 2'd3
    } state_t;

    // Index width for n items; never narrower than one bit.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/reg_bank_bus_arbiter_if.sv
// Requester-side and bank-side signals of the register-bank arbiter.
interface reg_bank_bus_arbiter_if #(
    parameter int NrOfReq  = 2,
    parameter int NrOfRegs = 8,
    parameter int AddrBits = 3,
    parameter int NrOfBits = 8
);
    logic [NrOfReq-1:0]          req;
    logic [NrOfReq-1:0]          we;
    logic [NrOfReq*AddrBits-1:0] addr;
    logic [NrOfReq*NrOfBits-1:0] wdata;
    logic [NrOfReq-1:0]          ack;
    logic [NrOfBits-1:0]         rdata;
    logic                        busy;
    logic [NrOfRegs-1:0]         reg_ce;
    logic [NrOfRegs-1:0]         reg_cs;
    logic [NrOfBits-1:0]         reg_d;
    logic [NrOfBits-1:0]         reg_q;

    modport slave (
        input  req, we, addr, wdata, reg_q,
        output ack, rdata, busy, reg_ce, reg_cs, reg_d
    );

    modport master (
        output req, we, addr, wdata, reg_q,
        input  ack, rdata, busy, reg_ce, reg_cs, reg_d
    );
endinterface

// File: rtl/reg_bank_bus_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester above ptr, wrapping.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);
    always_comb begin : pick
        int  c;
        logic found;
        c     = 0;
        found = 1'b0;
        gnt   = '0;
        idx   = '0;
        for (int k = 1; k <= N; k++) begin
            c = (int'(ptr) + k) % N;
            if (!found && req[c]) begin
                found  = 1'b1;
                gnt[c] = 1'b1;
                idx    = IW'(c);
            end
        end
    end
endmodule

// File: rtl/reg_bank_bus_arbiter.sv
// Round-robin arbiter sharing one tri-state register bank between requesters.
module reg_bank_bus_arbiter
    import reg_bank_arb_pkg::*;
#(
    parameter int NrOfReq  = 2,
    parameter int NrOfRegs = 8,
    parameter int AddrBits = 3,
    parameter int NrOfBits = 8
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   Tick,
    reg_bank_bus_arbiter_if.slave  bus
);
    localparam int IW = clog2(NrOfReq);

    state_t                state, state_nxt;
    logic [IW-1:0]         ptr, g_idx, arb_idx;
    logic [NrOfReq-1:0]    arb_gnt;
    logic [AddrBits-1:0]   l_addr, addr_sel, dec_addr;
    logic                  we_sel;
    logic [NrOfBits-1:0]   wdata_sel;
    logic [NrOfRegs-1:0]   ce_nxt, cs_nxt;
    logic [NrOfReq-1:0]    ack_nxt;

    // Out-of-range addresses decode to no select line at all.
    function automatic logic [NrOfRegs-1:0] dec(input logic [AddrBits-1:0] a);
        dec = '0;
        for (int i = 0; i < NrOfRegs; i++)
            if (int'(a) == i) dec[i] = 1'b1;
    endfunction

    rr_arbiter #(.N(NrOfReq), .IW(IW)) u_arb (
        .req (bus.req),
        .ptr (ptr),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    assign addr_sel  = bus.addr[arb_idx*AddrBits +: AddrBits];
    assign we_sel    = bus.we[arb_idx];
    assign wdata_sel = bus.wdata[arb_idx*NrOfBits +: NrOfBits];
    assign dec_addr  = (state == IDLE) ? addr_sel : l_addr;
    assign bus.busy  = (state != IDLE);

    always_comb begin
        state_nxt = state;
        ce_nxt    = '0;
        cs_nxt    = '1;
        ack_nxt   = '0;
        case (state)
            IDLE:    if (|arb_gnt) state_nxt = we_sel ? WRITE : READ;
            READ:    state_nxt = ACK;
            WRITE:   if (Tick) state_nxt = ACK;
            default: state_nxt = IDLE;
        endcase
        // Bank controls are registered from the next state, so they are glitch-free.
        case (state_nxt)
            READ:    cs_nxt = ~dec(dec_addr);
            WRITE:   ce_nxt = dec(dec_addr);
            ACK:     ack_nxt[g_idx] = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            ptr        <= IW'(NrOfReq - 1);
            g_idx      <= '0;
            l_addr     <= '0;
            bus.ack    <= '0;
            bus.rdata  <= '0;
            bus.reg_ce <= '0;
            bus.reg_cs <= '1;
            bus.reg_d  <= '0;
        end else begin
            state      <= state_nxt;
            bus.ack    <= ack_nxt;
            bus.reg_ce <= ce_nxt;
            bus.reg_cs <= cs_nxt;
            if (state == IDLE && |arb_gnt) begin
                g_idx  <= arb_idx;
                l_addr <= addr_sel;
                if (we_sel) bus.reg_d <= wdata_sel;
            end
            if (state == READ)
                bus.rdata <= (int'(l_addr) < NrOfRegs) ? bus.reg_q : '0;
            if (state == ACK)
                ptr <= g_idx;
        end
    end
endmodule

// File: tb/tb_reg_bank_bus_arbiter.sv
// Directed bench with a bank model and an ack/rdata scoreboard.
module tb_reg_bank_bus_arbiter;
    localparam int NREQ = 2, NREGS = 6, AB = 3, NB = 8;

    logic Clock = 1'b0, Reset = 1'b1, Tick = 1'b1;
    always #5 Clock = ~Clock;

    reg_bank_bus_arbiter_if #(.NrOfReq(NREQ), .NrOfRegs(NREGS), .AddrBits(AB), .NrOfBits(NB)) bif ();

    reg_bank_bus_arbiter #(.NrOfReq(NREQ), .NrOfRegs(NREGS), .AddrBits(AB), .NrOfBits(NB)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .Tick  (Tick),
        .bus   (bif.slave)
    );

    int total = 0, bad = 0;
    int ack_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Bank model: presets on Reset, Tick-qualified load, undriven bus reads as 0.
    logic [NB-1:0] bank [NREGS];
    int            load_cnt [NREGS];
    initial for (int i = 0; i < NREGS; i++) load_cnt[i] = 0;

    always @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NREGS; i++) bank[i] <= 8'h10 + 8'(i);
        end else begin
            for (int i = 0; i < NREGS; i++)
                if (Tick && bif.reg_ce[i]) begin
                    bank[i]     <= bif.reg_d;
                    load_cnt[i] <= load_cnt[i] + 1;
                end
        end
    end

    always_comb begin
        bif.reg_q = '0;
        for (int i = 0; i < NREGS; i++)
            if (!bif.reg_cs[i]) bif.reg_q = bank[i];
    end

    typedef struct {
        int          who;
        bit          chk_data;
        logic [NB-1:0] data;
    } exp_t;
    exp_t sbq [$];

    always @(negedge Clock) begin : monitor
        exp_t x;
        if (!Reset) begin
            chk("cs_one_low", 32'($countones(~bif.reg_cs) <= 1), 32'd1);
            chk("ce_one_high", 32'($countones(bif.reg_ce) <= 1), 32'd1);
            if (|bif.ack) begin
                ack_cnt++;
                if (sbq.size() == 0) begin
                    chk("unexpected_ack", 32'(bif.ack), 32'd0);
                end else begin
                    x = sbq.pop_front();
                    chk("ack_who", 32'(bif.ack), 32'(1 << x.who));
                    if (x.chk_data) chk("rdata", 32'(bif.rdata), 32'(x.data));
                end
            end
        end
    end

    int lat, ce_cyc, cs_cyc;
    logic [NREGS-1:0] ce_val, cs_val;

    task automatic push(input int who, input bit cd, input logic [NB-1:0] d);
        exp_t x;
        x.who = who; x.chk_data = cd; x.data = d;
        sbq.push_back(x);
    endtask

    // Called at posedge+1; lat counts negedges until ack (3 = ack two edges after presentation).
    task automatic do_txn(input int r, input bit w, input int a, input logic [NB-1:0] d, input logic [NB-1:0] e);
        logic [AB-1:0] a3;
        a3 = AB'(a);
        push(r, !w, e);
        bif.req[r] = 1'b1;
        bif.we[r]  = w;
        bif.addr[r*AB +: AB]  = a3;
        bif.wdata[r*NB +: NB] = d;
        lat = 0; ce_cyc = 0; cs_cyc = 0; ce_val = '0; cs_val = '1;
        while (lat < 60) begin
            @(negedge Clock);
            lat++;
            if (bif.reg_ce != '0) begin ce_cyc++; ce_val = bif.reg_ce; end
            if (bif.reg_cs != '1) begin cs_cyc++; cs_val = bif.reg_cs; end
            if (bif.ack[r]) break;
        end
        @(posedge Clock); #1;
        bif.req[r] = 1'b0;
    endtask

    task automatic both_reads(input int n, input int a0, input int a1,
                              input logic [NB-1:0] e0, input logic [NB-1:0] e1);
        int base, cyc, who;
        logic [AB-1:0] x0, x1;
        x0 = AB'(a0); x1 = AB'(a1);
        for (int k = 0; k < n; k++) begin
            who = k % 2;
            push(who, 1'b1, (who == 0) ? e0 : e1);
        end
        bif.we = '0;
        bif.addr[0 +: AB]  = x0;
        bif.addr[AB +: AB] = x1;
        bif.req = 2'b11;
        base = ack_cnt; cyc = 0;
        while (ack_cnt < base + n && cyc < 100) begin
            @(posedge Clock); #1;
            cyc++;
        end
        bif.req = '0;
        chk("both_done", 32'(ack_cnt - base), 32'(n));
    endtask

    initial begin
        int base, lc1;
        bif.req = '0; bif.we = '0; bif.addr = '0; bif.wdata = '0;
        repeat (3) @(posedge Clock);
        #1 Reset = 1'b0;
        #1;
        chk("rst_ack", 32'(bif.ack), 32'd0);
        chk("rst_busy", 32'(bif.busy), 32'd0);
        chk("rst_ce", 32'(bif.reg_ce), 32'd0);
        chk("rst_cs", 32'(bif.reg_cs), 32'h3f);
        chk("rst_d", 32'(bif.reg_d), 32'd0);
        chk("rst_rdata", 32'(bif.rdata), 32'd0);
        @(posedge Clock); #1;

        // Write then read back addr 3.
        do_txn(0, 1'b1, 3, 8'hA5, 8'h00);
        chk("wr_lat", 32'(lat), 32'd3);
        chk("wr_ce_cycles", 32'(ce_cyc), 32'd1);
        chk("wr_ce_val", 32'(ce_val), 32'b001000);
        chk("wr_bank3", 32'(bank[3]), 32'hA5);
        do_txn(0, 1'b0, 3, 8'h00, 8'hA5);
        chk("rd_lat", 32'(lat), 32'd3);
        chk("rd_cs_cycles", 32'(cs_cyc), 32'd1);
        chk("rd_cs_val", 32'(cs_val), 32'b110111);
        chk("rd_ce_cycles", 32'(ce_cyc), 32'd0);

        // Write waits for Tick: low for 5 edges in WRITE, then high.
        Tick = 1'b0;
        lc1 = load_cnt[1];
        fork
            begin
                repeat (6) @(posedge Clock);
                #1 Tick = 1'b1;
            end
        join_none
        do_txn(1, 1'b1, 1, 8'h3C, 8'h00);
        chk("tick_lat", 32'(lat), 32'd8);
        chk("tick_ce_cycles", 32'(ce_cyc), 32'd6);
        chk("tick_ce_val", 32'(ce_val), 32'b000010);
        chk("tick_loads", 32'(load_cnt[1] - lc1), 32'd1);
        chk("tick_bank1", 32'(bank[1]), 32'h3C);

        // Both requesting continuously: grants alternate 0,1,0,1.
        both_reads(4, 3, 1, 8'hA5, 8'h3C);

        // Out-of-range read.
        do_txn(0, 1'b0, 7, 8'h00, 8'h00);
        chk("oor_cs_cycles", 32'(cs_cyc), 32'd0);
        chk("oor_ce_cycles", 32'(ce_cyc), 32'd0);
        chk("oor_lat", 32'(lat), 32'd3);

        // Requester 1 drops req and changes addr while its read is in flight.
        push(1, 1'b1, 8'h12);
        bif.we[1] = 1'b0;
        bif.addr[AB +: AB] = 3'd2;
        bif.req[1] = 1'b1;
        base = ack_cnt;
        @(posedge Clock); #1;
        @(posedge Clock); #1;
        bif.req[1] = 1'b0;
        bif.addr[AB +: AB] = 3'd4;
        repeat (8) @(posedge Clock);
        #1 chk("drop_ack_once", 32'(ack_cnt - base), 32'd1);

        // Reset in the middle of a Tick-stalled write.
        Tick = 1'b0;
        bif.we[0] = 1'b1;
        bif.addr[0 +: AB] = 3'd4;
        bif.wdata[0 +: NB] = 8'h77;
        bif.req[0] = 1'b1;
        base = ack_cnt;
        @(posedge Clock); #1;
        @(posedge Clock); #1;
        chk("pre_rst_ce", 32'(bif.reg_ce), 32'b010000);
        Reset = 1'b1;
        #1;
        chk("mid_rst_ce", 32'(bif.reg_ce), 32'd0);
        chk("mid_rst_cs", 32'(bif.reg_cs), 32'h3f);
        chk("mid_rst_busy", 32'(bif.busy), 32'd0);
        chk("mid_rst_ack", 32'(bif.ack), 32'd0);
        bif.req = '0;
        @(posedge Clock); #1;
        Reset = 1'b0;
        Tick = 1'b1;
        @(posedge Clock); #1;
        chk("rst_no_ack", 32'(ack_cnt - base), 32'd0);
        both_reads(2, 3, 1, 8'h13, 8'h11);

        repeat (5) @(posedge Clock);
        #1 chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/reg_bank_bus_arbiter.md
Name: reg_bank_bus_arbiter

Overview:
- Shares one bank of tri-state-output bank registers (preset/reset-capable, Tick-qualified write) between several requesters, e.g. the core datapath and the image-load/accelerator engine.
- Grants one requester at a time using round-robin arbitration.
- Per transaction it drives the write enable and output-select lines of exactly one register, and returns read data with an ack.
- Guarantees that at most one register drives the shared read bus.

Parameters:
- NrOfReq, 2, number of requesters (2..8)
- NrOfRegs, 8, number of registers in the bank (2..2^AddrBits)
- AddrBits, 3, register address width
- NrOfBits, 8, register data width

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high
- Tick  in  1  global clock-enable tick; bank registers load only on edges with Tick=1
- req  in  NrOfReq  per-requester request, level; held until ack
- we  in  NrOfReq  per-requester 1=write, 0=read; held with req
- addr  in  NrOfReq*AddrBits  flattened; requester i at [i*AddrBits +: AddrBits]
- wdata  in  NrOfReq*NrOfBits  flattened; requester i at [i*NrOfBits +: NrOfBits]
- ack  out  NrOfReq  one-cycle completion pulse to the granted requester
- rdata  out  NrOfBits  read result; valid in the ack cycle, held until the next read completes
- busy  out  1  high in every state except IDLE
- reg_ce  out  NrOfRegs  per-register ClockEnable, at most one bit high
- reg_cs  out  NrOfRegs  per-register output select; 1 = high-Z, 0 = drive bus; at most one bit 0
- reg_d  out  NrOfBits  write data to all registers' D inputs
- reg_q  in  NrOfBits  shared tri-state read bus

Behaviour:
- Reset (async, any state):
  - state=IDLE; ack=0; busy=0; reg_ce=0; reg_cs=all 1; reg_d=0; rdata=0.
  - Round-robin pointer=NrOfReq-1, so requester 0 has first priority.
- States: IDLE, READ, WRITE, ACK. Encoding lives in the package.
- IDLE:
  - If any req is high, grant the first requester with req=1, searching from pointer+1 upward with wrap modulo NrOfReq.
  - Latch grant index g, addr[g], we[g], wdata[g].
  - Next state is WRITE if we=1, else READ.
  - No req: stay in IDLE.
- READ (1 cycle):
  - reg_cs[addr]=0, all other bits 1.
  - Sample reg_q into rdata at the rising edge, then go to ACK.
  - Tick is not required for reads.
- WRITE:
  - reg_d=latched wdata; reg_ce[addr]=1; reg_cs=all 1 (no bus drive).
  - Stay in WRITE until a rising edge with Tick=1, then go to ACK.
  - reg_ce deasserts on entry to ACK, so exactly one Tick-qualified load occurs.
- ACK (1 cycle):
  - ack[g]=1; reg_ce=0; reg_cs=all 1.
  - pointer<=g; next state IDLE.
  - A new grant can happen no earlier than the cycle after ACK.
- Latency with Tick held high: grant edge to ack = 2 cycles for both read and write.
  - A write additionally waits for Tick.
- Latched request: requests are latched at grant. A requester dropping req or changing addr/wdata mid-transaction does not abort the transaction; ack is still pulsed.
- Out-of-range address (addr >= NrOfRegs):
  - No reg_ce or reg_cs bit is activated.
  - A read returns rdata=0.
  - The transaction still completes with ack.
- Bus safety: reg_cs and reg_ce are registered, decoded from state and latched addr. No glitches, and never two zeros in reg_cs.
- Tick in READ/IDLE/ACK: ignored.
- Reset mid-WRITE: reg_ce drops asynchronously and no ack is issued. The target register may or may not have loaded, depending on edge ordering; the bench must not check the register value in this case.

Decomposition:
- Package reg_bank_arb_pkg holds: state encoding constants (IDLE=2'd0, READ=2'd1, WRITE=2'd2, ACK=2'd3), and the clog2 helper used for the grant-index width.
- One sub-module, rr_arbiter:
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant plus grant index.
  - Purely combinational; the parent registers its outputs.

Test Plan:
- Reset, then requester 0 writes addr=3, wdata=8'hA5, with Tick=1 -> reg_ce=8'b0000_1000 for 1 cycle, ack[0] 2 cycles after grant; a follow-up read of addr=3 with a bank model -> reg_cs=8'b1111_0111 for 1 cycle, rdata=8'hA5 in the ack cycle.
- Write with Tick low for 5 cycles, then high -> reg_ce stays 8'b0000_0010 (addr=1) for 6 cycles; ack exactly 1 cycle after the Tick edge; model register loads once.
- req=2'b11 held continuously, both reads -> grants alternate 0,1,0,1; ack pattern alternates; no two consecutive acks to the same requester.
- Read of addr=7 with NrOfRegs=6 -> reg_cs stays all 1, reg_ce=0, rdata=0, ack still pulsed.
- Requester 1 drops req and changes addr in the READ cycle -> original addr is still read; ack[1] pulses once.
- Assert Reset during WRITE -> reg_ce=0 and reg_cs=all 1 immediately; state IDLE; no ack; next grant goes to requester 0 when both request.
